// File: rtl/dma_priority_resolver_pkg.sv
// dma_pkg: shared definitions for the DMA priority resolver slice.
//   NUM_CH        number of DMA channels (only 4 supported)
//   state_t       resolver FSM states (IDLE, REQ, GRANT)
//   CMD_*         bit positions inside commandReg used by the resolver
package dma_pkg;

  localparam int NUM_CH = 4;

  // commandReg bit indices
  localparam int CMD_DISABLE   = 2;
  localparam int CMD_ROTATE    = 4;
  localparam int CMD_DREQ_LOW  = 6;
  localparam int CMD_DACK_HIGH = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    GRANT = 2'd2
  } state_t;

endpackage

// File: rtl/dma_priority_resolver_if.sv
// DmaRegIf: programming-register bundle shared by the DMA controller stages.
//   commandReg  [7:0]  controller command register
//   requestReg  [3:0]  software request bits, one per channel
//   maskReg     [3:0]  per-channel mask bits
// Modports:
//   master  register file side, drives all registers
//   PR      priority resolver view, read-only
//   slave   generic read-only consumer view (same as PR)
interface DmaRegIf;
  import dma_pkg::*;

  logic [7:0]        commandReg;
  logic [NUM_CH-1:0] requestReg;
  logic [NUM_CH-1:0] maskReg;

  modport master (output commandReg, output requestReg, output maskReg);
  modport PR     (input  commandReg, input  requestReg, input  maskReg);
  modport slave  (input  commandReg, input  requestReg, input  maskReg);

endinterface

// File: rtl/dma_priority_resolver_arbiter.sv
// dma_prio_arbiter: purely combinational channel picker.
//   eff        [3:0]  effective per-channel requests
//   ptr        [1:0]  channel holding highest priority in rotating mode
//   rotate_en         1 = rotating priority from ptr, 0 = fixed (ch0 highest)
//   winner     [1:0]  index of the highest-priority requesting channel
//   any_req           at least one eff bit is set
module dma_prio_arbiter
  import dma_pkg::*;
(
  input  logic [NUM_CH-1:0] eff,
  input  logic [1:0]        ptr,
  input  logic              rotate_en,
  output logic [1:0]        winner,
  output logic              any_req
);

  logic [1:0] base;
  logic       found;
  logic [1:0] idx;

  // Walk the channels starting at the highest-priority one; in fixed mode the
  // walk always starts at ch0. Index arithmetic wraps naturally in 2 bits.
  always_comb begin
    base   = rotate_en ? ptr : 2'd0;
    winner = 2'd0;
    found  = 1'b0;
    idx    = 2'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = base + 2'(k);
      if (!found && eff[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req = |eff;

endmodule

// File: rtl/dma_priority_resolver.sv
// dma_priority_resolver: request arbitration and HRQ/HLDA hold handshake of
// an 8237A-style DMA controller. Grants one channel to the timing-control
// stage and returns to arbitration on serviceDone or when HLDA is withdrawn.
// Ports:
//   CLK          system clock, rising edge
//   RESET        synchronous active-high reset
//   regIf        DmaRegIf.PR view of commandReg/requestReg/maskReg
//   DREQ   [3:0] channel requests, polarity set by commandReg[6]
//   HLDA         hold acknowledge from the CPU
//   serviceDone  one-cycle pulse: active channel service finished
//   HRQ          hold request to the CPU (REQ and GRANT)
//   DACK   [3:0] channel acknowledge, polarity set by commandReg[7]
//   activeCh[1:0] granted channel index
//   chValid      activeCh valid (GRANT)
//   reqStatus[3:0] registered per-channel request state for statusReg[7:4]
// Build option:
//   DMA_DREQ_SYNC_EN  adds a 2-flop synchronizer in front of the DREQ
//                     sampling register (2 extra cycles of request latency).
module dma_priority_resolver
  import dma_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  DmaRegIf.PR               regIf,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              HLDA,
  input  logic              serviceDone,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic [1:0]        activeCh,
  output logic              chValid,
  output logic [NUM_CH-1:0] reqStatus
);

  state_t            state, state_next;
  logic [NUM_CH-1:0] dreq_in;
  logic [NUM_CH-1:0] dreq_q;
  logic [NUM_CH-1:0] dreq_act;
  logic [NUM_CH-1:0] eff;
  logic [NUM_CH-1:0] ack;
  logic [1:0]        rot_ptr;
  logic [1:0]        winner;
  logic              any_req;
  logic              grant_load;
  logic              svc_done;
  logic              unused_cmd_bits;

  // Bits 0, 1, 3 and 5 of commandReg belong to other stages.
  assign unused_cmd_bits = ^{regIf.commandReg[5], regIf.commandReg[3],
                             regIf.commandReg[1], regIf.commandReg[0]};

`ifdef DMA_DREQ_SYNC_EN
  logic [NUM_CH-1:0] sync_1;
  logic [NUM_CH-1:0] sync_2;

  // Two-flop synchronizer for DREQ lines that are asynchronous to CLK.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= DREQ;
      sync_2 <= sync_1;
    end
  end

  assign dreq_in = sync_2;
`else
  assign dreq_in = DREQ;
`endif

  // Request conditioning: polarity, mask, then non-maskable software requests.
  assign dreq_act = dreq_q ^ {NUM_CH{regIf.commandReg[CMD_DREQ_LOW]}};
  assign eff      = (dreq_act & ~regIf.maskReg) | regIf.requestReg;

  dma_prio_arbiter u_arbiter (
    .eff       (eff),
    .ptr       (rot_ptr),
    .rotate_en (regIf.commandReg[CMD_ROTATE]),
    .winner    (winner),
    .any_req   (any_req)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Disable only blocks leaving IDLE; REQ and GRANT run to completion.
  // serviceDone wins over a simultaneous HLDA drop so the rotation advances.
  always_comb begin
    state_next = state;
    grant_load = 1'b0;
    svc_done   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req && !regIf.commandReg[CMD_DISABLE]) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (!any_req) begin
          state_next = IDLE;
        end else if (HLDA) begin
          state_next = GRANT;
          grant_load = 1'b1;
        end
      end
      GRANT: begin
        if (serviceDone) begin
          state_next = IDLE;
          svc_done   = 1'b1;
        end else if (!HLDA) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers: DREQ sample, status, latched grant and rotation pointer.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dreq_q    <= '0;
      reqStatus <= '0;
      activeCh  <= 2'd0;
      rot_ptr   <= 2'd0;
    end else begin
      dreq_q    <= dreq_in;
      reqStatus <= dreq_act | regIf.requestReg;
      if (grant_load) begin
        activeCh <= winner;
      end
      if (svc_done) begin
        rot_ptr <= activeCh + 2'd1;
      end
    end
  end

  assign HRQ     = (state != IDLE);
  assign chValid = (state == GRANT);
  assign ack     = (state == GRANT) ? (4'b0001 << activeCh) : '0;
  assign DACK    = regIf.commandReg[CMD_DACK_HIGH] ? ack : ~ack;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// tb_dma_priority_resolver: self-checking bench for dma_priority_resolver
// (default build, DMA_DREQ_SYNC_EN undefined). Table-driven fixed-priority
// sequence, hand-written corner-case sequences, and randomized stimulus
// checked against a cycle-level reference model of the resolver rules.
module tb_dma_priority_resolver;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] DREQ = 4'h0;
  logic       HLDA = 1'b0;
  logic       serviceDone = 1'b0;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] activeCh;
  logic       chValid;
  logic [3:0] reqStatus;

  int check_cnt = 0;
  int pass_cnt  = 0;

  DmaRegIf reg_if ();

  dma_priority_resolver dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .regIf       (reg_if),
    .DREQ        (DREQ),
    .HLDA        (HLDA),
    .serviceDone (serviceDone),
    .HRQ         (HRQ),
    .DACK        (DACK),
    .activeCh    (activeCh),
    .chValid     (chValid),
    .reqStatus   (reqStatus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: run still active at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- reference model (spec-level rules) ----------------
  localparam int M_IDLE  = 0;
  localparam int M_REQ   = 1;
  localparam int M_GRANT = 2;

  logic [3:0] m_samp;
  logic [3:0] m_stat;
  int         m_state;
  int         m_ptr;
  int         m_act;

  task automatic model_reset();
    m_samp  = 4'h0;
    m_stat  = 4'h0;
    m_state = M_IDLE;
    m_ptr   = 0;
    m_act   = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [3:0] act;
    logic [3:0] eff;
    logic [7:0] cmd;
    int         base;
    int         win;
    bit         found;
    bit         any;
    cmd   = reg_if.commandReg;
    act   = m_samp ^ (cmd[6] ? 4'hF : 4'h0);
    eff   = (act & ~reg_if.maskReg) | reg_if.requestReg;
    any   = (eff != 4'h0);
    base  = cmd[4] ? m_ptr : 0;
    win   = 0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (base + k) % 4;
      if (!found && eff[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    case (m_state)
      M_IDLE:  if (any && !cmd[2]) m_state = M_REQ;
      M_REQ: begin
        if (!any) m_state = M_IDLE;
        else if (HLDA) begin
          m_state = M_GRANT;
          m_act   = win;
        end
      end
      default: begin
        if (serviceDone) begin
          m_state = M_IDLE;
          m_ptr   = (m_act + 1) % 4;
        end else if (!HLDA) begin
          m_state = M_IDLE;
        end
      end
    endcase
    m_stat = act | reg_if.requestReg;
    m_samp = DREQ;
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
  endtask

  task automatic apply_stimulus(input logic [3:0] dreq, input logic hlda,
                                input logic svc);
    DREQ        = dreq;
    HLDA        = hlda;
    serviceDone = svc;
  endtask

  task automatic do_reset(input logic [7:0] cmd);
    reg_if.commandReg = cmd;
    serviceDone = 1'b0;
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic pulse_service();
    serviceDone = 1'b1;
    tick();
    serviceDone = 1'b0;
  endtask

  // Wait (bounded) for GRANT, then compare the granted channel.
  task automatic wait_grant(input int max_cycles, input logic [1:0] exp_ch,
                            input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick();
      if (chValid === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      check_cnt++;
      $display("[TB] FAIL %s: no grant within %0d cycles, required grant of ch%0d",
               name, max_cycles, exp_ch);
    end else begin
      check_output(name, 8'(activeCh), 8'(exp_ch));
    end
  endtask

  task automatic run_random(input logic rot, input int n);
    logic [7:0] cmd;
    logic [3:0] oh;
    logic [3:0] exp_dack;
    cmd    = 8'h00;
    cmd[4] = rot;
    reg_if.maskReg    = 4'h0;
    reg_if.requestReg = 4'h0;
    apply_stimulus(4'h0, 1'b0, 1'b0);
    do_reset(cmd);
    model_reset();
    for (int i = 0; i < n; i++) begin
      if (i % 32 == 0) begin
        cmd    = 8'($urandom);
        cmd[4] = rot;
        if ($urandom_range(0, 3) != 0) cmd[2] = 1'b0;
        reg_if.commandReg = cmd;
      end
      DREQ        = 4'($urandom);
      HLDA        = ($urandom_range(0, 7) != 0);
      serviceDone = ($urandom_range(0, 3) == 0);
      reg_if.maskReg    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      reg_if.requestReg = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      model_step();
      tick();
      oh       = (m_state == M_GRANT) ? (4'b0001 << m_act) : 4'h0;
      exp_dack = cmd[7] ? oh : ~oh;
      check_output("rand_hrq", 8'(HRQ), 8'(m_state != M_IDLE));
      check_output("rand_chvalid", 8'(chValid), 8'(m_state == M_GRANT));
      check_output("rand_dack", 8'(DACK), 8'(exp_dack));
      check_output("rand_reqstatus", 8'(reqStatus), 8'(m_stat));
      if (m_state == M_GRANT) check_output("rand_activech", 8'(activeCh), 8'(m_act));
    end
    serviceDone = 1'b0;
  endtask

  // ---------------- fixed-priority vector table ----------------
  typedef struct {
    logic [3:0] dreq;
    logic       hlda;
    logic       svc;
    logic       exp_hrq;
    logic       exp_chv;
    logic [1:0] exp_ch;
    logic [3:0] exp_dack;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic       seen_hrq;
    logic [3:0] exp_dack;

    // DREQ=1010, fixed priority: ch1 wins, HLDA two cycles after HRQ,
    // service ends, one-cycle gap, ch1 again, then requests go away.
    vecs[0]  = '{4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'hF};
    vecs[1]  = '{4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'hF};
    vecs[2]  = '{4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'hF};
    vecs[3]  = '{4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'hF};
    vecs[4]  = '{4'hA, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 4'hD};
    vecs[5]  = '{4'hA, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 4'hD};
    vecs[6]  = '{4'hA, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'hF};
    vecs[7]  = '{4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'hF};
    vecs[8]  = '{4'hA, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 4'hD};
    vecs[9]  = '{4'hA, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'hF};
    vecs[10] = '{4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'hF};
    vecs[11] = '{4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'hF};
    vecs[12] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'hF};

    reg_if.commandReg = 8'h00;
    reg_if.maskReg    = 4'h0;
    reg_if.requestReg = 4'h0;

    // Reset state
    do_reset(8'h00);
    check_output("reset_hrq", 8'(HRQ), 8'h0);
    check_output("reset_chvalid", 8'(chValid), 8'h0);
    check_output("reset_activech", 8'(activeCh), 8'h0);
    check_output("reset_reqstatus", 8'(reqStatus), 8'h0);
    check_output("reset_dack", 8'(DACK), 8'hF);

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].dreq, vecs[i].hlda, vecs[i].svc);
      tick();
      check_output($sformatf("vec%0d_hrq", i), 8'(HRQ), 8'(vecs[i].exp_hrq));
      check_output($sformatf("vec%0d_chvalid", i), 8'(chValid), 8'(vecs[i].exp_chv));
      check_output($sformatf("vec%0d_dack", i), 8'(DACK), 8'(vecs[i].exp_dack));
      if (vecs[i].exp_chv)
        check_output($sformatf("vec%0d_activech", i), 8'(activeCh), 8'(vecs[i].exp_ch));
    end
    serviceDone = 1'b0;

    // Rotating priority: all four channels requesting, grants rotate 0..3
    do_reset(8'h10);
    apply_stimulus(4'hF, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_grant(10, 2'(k), $sformatf("rot_order%0d", k));
      exp_dack = ~(4'b0001 << k);
      check_output($sformatf("rot_dack%0d", k), 8'(DACK), 8'(exp_dack));
      pulse_service();
      check_output($sformatf("rot_gap%0d", k), 8'(HRQ), 8'h0);
    end

    // Mask blocks hardware requests; software request is not maskable
    do_reset(8'h00);
    reg_if.maskReg = 4'hF;
    apply_stimulus(4'hF, 1'b1, 1'b0);
    seen_hrq = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen_hrq |= HRQ;
    end
    check_output("mask_hrq", 8'(seen_hrq), 8'h0);
    reg_if.requestReg = 4'b0100;
    wait_grant(10, 2'd2, "swreq_ch");
    check_output("swreq_reqstatus", 8'(reqStatus), 8'hF);
    check_output("swreq_dack", 8'(DACK), 8'hB);
    reg_if.requestReg = 4'h0;
    pulse_service();
    check_output("swreq_done_chvalid", 8'(chValid), 8'h0);
    tick();
    check_output("swreq_clear_hrq", 8'(HRQ), 8'h0);

    // Polarity: active-low DREQ, active-high DACK (mask still set while switching)
    reg_if.commandReg = 8'hC0;
    DREQ = 4'b1110;
    tick();
    tick();
    check_output("pol_dack_idle", 8'(DACK), 8'h0);
    reg_if.maskReg = 4'h0;
    wait_grant(10, 2'd0, "pol_ch");
    check_output("pol_dack_grant", 8'(DACK), 8'h1);
    DREQ = 4'hF;
    HLDA = 1'b0;
    pulse_service();
    check_output("pol_dack_after", 8'(DACK), 8'h0);
    check_output("pol_hrq_after", 8'(HRQ), 8'h0);
    tick();
    check_output("pol_inactive_hrq", 8'(HRQ), 8'h0);
    reg_if.commandReg = 8'h40;
    #1;
    check_output("pol_dack_comb", 8'(DACK), 8'hF);

    // Abort: HLDA withdrawn in GRANT leaves pointer where it was
    do_reset(8'h10);
    apply_stimulus(4'hF, 1'b1, 1'b0);
    wait_grant(10, 2'd0, "abort_first");
    HLDA = 1'b0;
    tick();
    check_output("abort_chvalid", 8'(chValid), 8'h0);
    check_output("abort_hrq", 8'(HRQ), 8'h0);
    HLDA = 1'b1;
    wait_grant(10, 2'd0, "abort_ptr_kept");

    // Disable: pending requests never raise HRQ
    do_reset(8'h04);
    apply_stimulus(4'hF, 1'b1, 1'b0);
    seen_hrq = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen_hrq |= HRQ;
    end
    check_output("disable_hrq", 8'(seen_hrq), 8'h0);
    reg_if.commandReg = 8'h00;
    wait_grant(10, 2'd0, "enable_grant");

    // Reset mid-GRANT clears outputs and the rotation pointer
    do_reset(8'h10);
    apply_stimulus(4'hF, 1'b1, 1'b0);
    wait_grant(10, 2'd0, "rst_first");
    pulse_service();
    wait_grant(10, 2'd1, "rst_second");
    RESET = 1'b1;
    tick();
    check_output("rst_hrq", 8'(HRQ), 8'h0);
    check_output("rst_chvalid", 8'(chValid), 8'h0);
    check_output("rst_dack", 8'(DACK), 8'hF);
    check_output("rst_activech", 8'(activeCh), 8'h0);
    RESET = 1'b0;
    wait_grant(10, 2'd0, "rst_ptr_cleared");

    // Randomized stimulus against the reference model
    run_random(1'b0, 400);
    run_random(1'b1, 400);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/dma_priority_resolver.md
# dma_priority_resolver

Request arbitration and hold-handshake stage of the 8237A-style DMA controller. Consumes channel DREQ lines plus the command, request and mask registers through the PR view of `DmaRegIf`. Resolves fixed or rotating priority, runs the HRQ/HLDA bus-hold handshake and drives DACK. It hands the granted channel to the timing-control stage and returns to arbitration when that stage signals end of service.

## Interface
- NUM_CH, 4, channel count; only 4 supported.
- CLK  input  1  system clock, all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- regIf  modport  DmaRegIf.PR  read-only view of commandReg, requestReg, maskReg.
- DREQ  input  4  channel DMA requests, polarity per commandReg[6].
- HLDA  input  1  hold acknowledge from CPU.
- serviceDone  input  1  one-cycle pulse from timing control: active channel service finished.
- HRQ  output  1  hold request to CPU.
- DACK  output  4  channel acknowledge, polarity per commandReg[7].
- activeCh  output  2  granted channel index.
- chValid  output  1  activeCh valid (state GRANT).
- reqStatus  output  4  per-channel request state for statusReg[7:4].

## Operation
- Active request per channel: dreqAct[i] = DREQ[i] XOR commandReg[6] (bit6 = 0 means active-high).
- Software request: requestReg[i], i in 0..3.
- Effective request: eff[i] = (dreqAct[i] AND NOT maskReg[i]) OR requestReg[i]. Software requests are not maskable.
- reqStatus[i] = dreqAct[i] OR requestReg[i], unmasked, registered.
- Priority:
  - commandReg[4] = 0: fixed priority, ch0 highest, ch3 lowest.
  - commandReg[4] = 1: rotating priority. After a completed service of channel n, channel n becomes lowest priority and (n+1) mod 4 becomes highest.
  - Rotation pointer resets to "ch0 highest".
- commandReg[2] = 1 (controller disable): no new transition out of IDLE. A GRANT already in progress completes normally.
- commandReg bits 0, 1, 3 and 5 are ignored by this block.
- FSM states IDLE, REQ, GRANT:
  - IDLE → REQ: any eff bit set and commandReg[2] = 0.
  - REQ → GRANT: HLDA = 1 and any eff bit set. Channel resolved from eff in that cycle and latched into activeCh.
  - REQ → IDLE: no eff bit set in a cycle. HRQ drops. HLDA is ignored in that cycle.
  - GRANT → IDLE on serviceDone = 1. Rotation pointer updated from activeCh.
  - GRANT → IDLE on HLDA = 0 (abort). Rotation pointer is not updated.
- GRANT ignores eff changes; the latched channel holds until exit.
- serviceDone outside GRANT is ignored.

## Timing
- Reset values:
  - HRQ = 0, chValid = 0, activeCh = 0, reqStatus = 0, state IDLE.
  - Internal ack = 0, so DACK = 4'hF while commandReg[7] = 0 (DACK always drives the inactive level of the current polarity).
- DREQ is sampled with one register stage.
- Cycle numbering:
  - DREQ asserted before edge N → eff seen in cycle N.
  - HRQ = 1 from cycle N+1 (state REQ).
- HLDA sampled high at edge M in REQ → cycle M+1: GRANT, DACK[ch] active, chValid = 1.
- serviceDone at edge K → cycle K+1: IDLE, HRQ = 0, DACK inactive, chValid = 0.
  - A new request re-raises HRQ no earlier than K+2, giving a mandatory one-cycle gap.
- HRQ = 1 in REQ and GRANT only.
- DACK is one-hot active only in GRANT.
- DACK polarity change (commandReg[7]) takes effect combinationally.
- RESET mid-GRANT: next cycle is reset state and the pointer is reset.

## Configuration
- DMA_DREQ_SYNC_EN defined:
  - DREQ passes through a 2-flop synchronizer ahead of the sampling register.
  - DREQ-to-HRQ latency grows by 2 cycles (HRQ at N+3).
  - Synchronizer flops reset to 0.
- DMA_DREQ_SYNC_EN undefined: single sampling register only. Use when DREQ is already synchronous to CLK.

## Structure
- Package dma_pkg:
  - NUM_CH.
  - State enum (IDLE, REQ, GRANT).
  - commandReg bit-index constants: CMD_DISABLE = 2, CMD_ROTATE = 4, CMD_DREQ_LOW = 6, CMD_DACK_HIGH = 7.
- Sub-module dma_prio_arbiter:
  - Purely combinational.
  - Inputs: eff[3:0], rotation pointer, rotate enable.
  - Outputs: winner index and any-request flag.
- FSM, pointer, DACK polarity and sampling/synchronizer logic stay in dma_priority_resolver.

## Test plan
- Fixed priority:
  - Stimulus: DREQ = 4'b1010, commandReg = 0, mask = 0. HLDA raised 2 cycles after HRQ.
  - Required: HRQ at N+1, GRANT with activeCh = 1, DACK = 4'b1101.
  - Stimulus: serviceDone.
  - Required: IDLE with one-cycle HRQ gap, then ch1 wins again.
- Rotating priority:
  - Stimulus: commandReg[4] = 1, DREQ = 4'b1111, four serviceDone pulses.
  - Required: grant order ch0, ch1, ch2, ch3.
- Mask and software request:
  - Stimulus: mask = 4'hF, DREQ = 4'hF.
  - Required: HRQ stays 0.
  - Stimulus: requestReg = 4'b0100.
  - Required: activeCh = 2; reqStatus = 4'hF.
- Polarity:
  - Stimulus: commandReg = 8'hC0, DREQ = 4'b1110.
  - Required: ch0 requests. DACK = 4'b0001 in GRANT, 4'b0000 in IDLE.
- Abort and disable:
  - Stimulus: HLDA drops in GRANT.
  - Required: IDLE next cycle, pointer unchanged.
  - Stimulus: commandReg[2] = 1 with requests pending.
  - Required: HRQ never asserts.
- Reset mid-GRANT:
  - Stimulus: RESET pulse in GRANT.
  - Required: next cycle HRQ = 0, chValid = 0, DACK = 4'hF.
